// File: rtl/led7seg_pkg.sv
// rtl/led7seg_pkg.sv - shared segment constants, pattern table and FSM states for led7seg_capture
package led7seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high abcdefg patterns for hex digits 0..F, bit SEG_A is segment a.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

endpackage

// File: rtl/led7seg_decode.sv
// rtl/led7seg_decode.sv - active-high 7-segment pattern to hex nibble with legality flag
module led7seg_decode
    import led7seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       legal
);

    always_comb begin
        value = '0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                value = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led7seg_capture.sv
// rtl/led7seg_capture.sv - samples a multiplexed 7-segment bus and rebuilds per-digit registers
module led7seg_capture
    import led7seg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 4,
    parameter int STALE_CYC   = 65535
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  LED,
    input  logic [3:0]  SA,
    output logic [15:0] HEX,
    output logic [3:0]  DP,
    output logic [3:0]  VALID,
    output logic        UPD,
    output logic [1:0]  UPD_IDX,
    output logic        ERR
);

    localparam int          CW        = $clog2(STABLE_CYC + 1);
    localparam logic [16:0] STALE_LIM = 17'(STALE_CYC);

    logic [11:0]   sync_q [SYNC_STAGES];
    logic [11:0]   s;
    logic [11:0]   prev;
    logic [3:0]    act;
    logic          one_hot;
    logic [1:0]    idx;
    logic          same;
    logic [6:0]    seg_on;
    logic [3:0]    dec_val;
    logic          dec_legal;
    logic          cap_cycle;
    logic          cap_ok;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   stale_cnt [4];

    assign s      = sync_q[SYNC_STAGES-1];
    assign same   = (s == prev);
    assign seg_on = ~s[SEG_G:SEG_A];

    // An anode counts as active only on a clean 0; X/Z fall to the inactive branch.
    always_comb begin
        act = '0;
        for (int i = 0; i < 4; i++) begin
            if (s[8+i] == 1'b0) act[i] = 1'b1;
        end
    end

    always_comb begin
        one_hot = 1'b1;
        idx     = 2'd0;
        case (act)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    led7seg_decode u_decode (
        .seg   (seg_on),
        .value (dec_val),
        .legal (dec_legal)
    );

    // The sample that brings the run length up to STABLE_CYC triggers the capture.
    assign cap_cycle = (state == TRACK) && one_hot && same && (cnt == CW'(STABLE_CYC - 1));
    assign cap_ok    = cap_cycle && dec_legal;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int d = 0; d < 4; d++) stale_cnt[d] <= '0;
            prev    <= '0;
            state   <= IDLE;
            cnt     <= '0;
            HEX     <= '0;
            DP      <= '0;
            VALID   <= '0;
            UPD     <= 1'b0;
            UPD_IDX <= 2'd0;
            ERR     <= 1'b0;
        end else begin
            sync_q[0] <= {SA, LED};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= s;
            UPD  <= cap_ok;

            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state <= TRACK;
                        cnt   <= CW'(1);
                    end
                end
                TRACK: begin
                    if (!one_hot) begin
                        state <= IDLE;
                    end else if (!same) begin
                        cnt <= CW'(1);
                    end else if (cap_cycle) begin
                        state <= LOCKED;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LOCKED: begin
                    if (!same) begin
                        state <= one_hot ? TRACK : IDLE;
                        cnt   <= CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (cap_ok) begin
                HEX[4*idx +: 4] <= dec_val;
                DP[idx]         <= ~s[SEG_DP];
                UPD_IDX         <= idx;
            end
            if (cap_cycle && !dec_legal) ERR <= 1'b1;

            // A capture on the threshold cycle takes priority over the stale clear.
            for (int d = 0; d < 4; d++) begin
                if (cap_ok && (idx == 2'(d))) begin
                    VALID[d]     <= 1'b1;
                    stale_cnt[d] <= '0;
                end else if (VALID[d]) begin
                    if (stale_cnt[d] != 16'hFFFF) stale_cnt[d] <= stale_cnt[d] + 16'd1;
                    if (({1'b0, stale_cnt[d]} + 17'd1) >= STALE_LIM) VALID[d] <= 1'b0;
                end
            end
        end
    end

endmodule
